cva6_ras_ckpt: RTL
==================

# cva6_ras_ckpt

Parametrised return-address stack (RAS) for the CVA6 frontend, successor to the fixed-depth RAS sized by `RASDepth`. It adds generic depth, an occupancy counter, circular overwrite on overflow and a checkpoint file. Branch-unit mispredicts can restore the speculative stack state without a full flush. It sits between the branch predictor (push/pop on call/return) and the controller (checkpoint save/restore, flush).

## Interface
- `DEPTH`, 2: number of stack entries; any value ≥ 2, need not be a power of two.
- `VLEN`, 64: return-address width.
- `NR_CKPT`, 4: number of checkpoint slots; ≥ 2.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `flush_i` in 1: empty the stack and invalidate all checkpoints.
- `push_i` in 1: push `push_addr_i`.
- `push_addr_i` in VLEN: address to push.
- `pop_i` in 1: pop top entry.
- `ckpt_save_i` in 1: save state into slot `ckpt_idx_i`.
- `ckpt_restore_i` in 1: restore state from slot `ckpt_idx_i`.
- `ckpt_idx_i` in $clog2(NR_CKPT): checkpoint slot index.
- `top_o` out VLEN: current top address; 0 when empty.
- `top_valid_o` out 1: stack non-empty.
- `count_o` out $clog2(DEPTH+1): occupancy.
- `ckpt_err_o` out 1: one-cycle pulse, restore from an invalid slot.

## Operation
- State: `entry[DEPTH]` of VLEN bits, `tos` pointer $clog2(DEPTH) bits, `count`, and per slot `{valid, tos, count, top}`.
- Pointer arithmetic wraps modulo DEPTH explicitly: `tos+1` is 0 when `tos==DEPTH-1`, and `tos-1` is `DEPTH-1` when `tos==0`.
- Per-cycle priority: `flush_i` > `ckpt_restore_i` > `push_i`/`pop_i`. Save is independent unless restore is also asserted, in which case save is ignored.
- Flush: `count`←0, `tos`←0, all slot valids cleared. Same-cycle push, pop, save and restore are ignored. `ckpt_err_o` stays 0.
- Push only: `tos`←`tos+1`, `entry[tos+1]`←addr, `count`←min(count+1, DEPTH). When full, the oldest entry is silently overwritten.
- Pop only: if count>0, `tos`←`tos-1` and `count`−1. If count==0, no state change.
- Push and pop together: `entry[tos]`←addr; `tos` and `count` unchanged. If count==0, treat as push only.
- Save: slot ← post-update `{tos, count, entry[tos]}` (this cycle's push/pop included); valid←1. Saving to a valid slot overwrites it.
- Restore from a valid slot: `tos`, `count` ← saved; `entry[saved tos]`← saved top. Slot stays valid.
- Restore from an invalid slot: state unchanged; `ckpt_err_o`=1 next cycle.
- Deeper entries are not repaired by a restore; overwritten lower entries stay corrupted. This is by design (single-top repair).

## Timing
- All state updates on the `clk_i` rising edge. Outputs are combinational from registers only; there is no input→output path.
- Latency is 1 cycle: a push at cycle N appears on `top_o` at N+1.
- Reset values: `tos`=0, `count`=0, entries 0, slots invalid, `top_o`=0, `top_valid_o`=0, `count_o`=0, `ckpt_err_o`=0.
- Reset mid-operation overrides all inputs in that cycle.
- `ckpt_err_o` is high for exactly one cycle per invalid restore.

## Structure
- Add `NrRasCheckpoints` (default 4) to `config_pkg::cva6_cfg_t`; `DEPTH` is taken from `RASDepth`.
- The slot record `ras_ckpt_t {valid, tos, count, top}` is a local parametrised typedef (it depends on VLEN and DEPTH), not a package type.
- One sub-module: `cva6_ras_ckpt_file`, the NR_CKPT-slot register file with write/read by index and a flush-clear of valid bits.

## Test plan
- Reset, then push 0x1000 and 0x2000 on consecutive cycles → `top_o`=0x2000, `count_o`=2. Pop → `top_o`=0x1000, `count_o`=1.
- DEPTH=4, push A1..A5 → `count_o`=4. Four pops return A5, A4, A3, A2. Then `top_valid_o`=0 and `top_o`=0. A further pop leaves `count_o`=0.
- Stack [0x1000, 0x2000], push 0x3000 and pop in the same cycle → `top_o`=0x3000, `count_o`=2.
- Stack [0x1000, 0x2000], save slot 1; pop, pop, push 0x9000; restore slot 1 → `top_o`=0x2000, `count_o`=2. Next pop → `top_o`=0x9000 (documented corruption).
- Save slot 0, then flush together with push 0x4000 → `count_o`=0. Restore slot 0 → `ckpt_err_o`=1 for one cycle and `count_o` stays 0.
- Restore and save to the same slot in the same cycle, with a valid checkpoint → restore applied, slot contents unchanged.

Source files
------------

// File: rtl/cva6_ras_ckpt_pkg.sv
// Shared definitions for the checkpointed return-address stack.
// Holds the frontend configuration record that sizes the RAS. It also holds
// the default widths that the interface and the top module inherit.
package cva6_ras_ckpt_pkg;

    // Frontend configuration fields that size the RAS and its checkpoint file.
    typedef struct packed {
        int unsigned RASDepth;
        int unsigned NrRasCheckpoints;
    } cva6_cfg_t;

    localparam cva6_cfg_t DefaultCfg = '{RASDepth: 2, NrRasCheckpoints: 4};
    localparam int unsigned DefaultVlen = 64;

endpackage

// File: rtl/cva6_ras_ckpt_if.sv
// Bundle between the branch predictor/controller (master) and the RAS (slave).
//   master drives: flush, push, push_addr, pop, ckpt_save, ckpt_restore, ckpt_idx
//   slave drives : top, top_valid, count, ckpt_err
// The parameters must match those of the cva6_ras_ckpt instance that uses it.
interface cva6_ras_ckpt_if
    import cva6_ras_ckpt_pkg::*;
#(
    parameter int unsigned VLEN    = DefaultVlen,
    parameter int unsigned DEPTH   = DefaultCfg.RASDepth,
    parameter int unsigned NR_CKPT = DefaultCfg.NrRasCheckpoints
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(NR_CKPT);

    logic             flush;
    logic             push;
    logic [VLEN-1:0]  push_addr;
    logic             pop;
    logic             ckpt_save;
    logic             ckpt_restore;
    logic [IDX_W-1:0] ckpt_idx;
    logic [VLEN-1:0]  top;
    logic             top_valid;
    logic [CNT_W-1:0] count;
    logic             ckpt_err;

    modport master (
        output flush, push, push_addr, pop, ckpt_save, ckpt_restore, ckpt_idx,
        input  top, top_valid, count, ckpt_err
    );

    modport slave (
        input  flush, push, push_addr, pop, ckpt_save, ckpt_restore, ckpt_idx,
        output top, top_valid, count, ckpt_err
    );
endinterface

// File: rtl/cva6_ras_ckpt_file.sv
// Checkpoint register file for the RAS: NR_CKPT slots, one write port and one
// combinational read port, both addressed by index. A flush clears every
// valid bit. Each slot is a flat packed record whose MSB is the valid flag.
// Ports:
//   clk, srst        clock, synchronous active-high reset
//   flush            clear all valid bits (wins over a same-cycle write)
//   wr_en/idx/data   slot write
//   rd_idx/rd_data   slot read; out-of-range indices read as an invalid slot
module cva6_ras_ckpt_file #(
    parameter int unsigned NR_CKPT = 4,
    parameter int unsigned SLOT_W  = 8
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [$clog2(NR_CKPT)-1:0] wr_idx,
    input  logic [SLOT_W-1:0]          wr_data,
    input  logic [$clog2(NR_CKPT)-1:0] rd_idx,
    output logic [SLOT_W-1:0]          rd_data
);
    localparam int unsigned IDX_W = $clog2(NR_CKPT);

    logic [SLOT_W-1:0]  slot_reg [NR_CKPT];
    logic [NR_CKPT-1:0] wr_hit;

    for (genvar gi = 0; gi < NR_CKPT; gi++) begin : g_hit
        assign wr_hit[gi] = wr_en && (wr_idx == IDX_W'(gi));
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NR_CKPT; i++) begin
            if (srst) begin
                slot_reg[i] <= '0;
            end else if (flush) begin
                slot_reg[i][SLOT_W-1] <= 1'b0;
            end else if (wr_hit[i]) begin
                slot_reg[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (32'(rd_idx) < NR_CKPT) begin
            rd_data = slot_reg[rd_idx];
        end
    end
endmodule

// File: rtl/cva6_ras_ckpt.sv
// Return-address stack with occupancy tracking, circular overwrite on overflow
// and checkpoint save/restore. A restore repairs only the top entry. Deeper
// entries that were overwritten after the save stay corrupted.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   ras (slave)    push/pop, checkpoint save/restore/index and flush in;
//                  top, top_valid, count and ckpt_err out (all driven from
//                  registers only)
// Priority each cycle: flush > restore > push/pop; save is dropped on a
// restore or flush cycle.
module cva6_ras_ckpt
    import cva6_ras_ckpt_pkg::*;
#(
    parameter int unsigned DEPTH   = DefaultCfg.RASDepth,
    parameter int unsigned VLEN    = DefaultVlen,
    parameter int unsigned NR_CKPT = DefaultCfg.NrRasCheckpoints
) (
    input logic            clk_i,
    input logic            rst_i,
    cva6_ras_ckpt_if.slave ras
);
    localparam int unsigned TOS_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Valid is the MSB; the checkpoint file relies on that position.
    typedef struct packed {
        logic             valid;
        logic [TOS_W-1:0] tos;
        logic [CNT_W-1:0] count;
        logic [VLEN-1:0]  top;
    } ras_ckpt_t;

    logic [VLEN-1:0]  entry_reg [DEPTH];
    logic [TOS_W-1:0] tos_reg, tos_next, tos_inc, tos_dec;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             ckpt_err_reg, ckpt_err_next;
    logic             wr_en;
    logic [TOS_W-1:0] wr_idx;
    logic [VLEN-1:0]  wr_data;
    logic [VLEN-1:0]  top_next;
    logic             save_en;
    ras_ckpt_t        save_slot, rd_slot;

    // Explicit modulo-DEPTH wrap so non-power-of-two depths work.
    assign tos_inc = (tos_reg == TOS_W'(DEPTH - 1)) ? '0 : tos_reg + 1'b1;
    assign tos_dec = (tos_reg == '0) ? TOS_W'(DEPTH - 1) : tos_reg - 1'b1;

    always_comb begin
        tos_next      = tos_reg;
        count_next    = count_reg;
        ckpt_err_next = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = tos_inc;
        wr_data       = ras.push_addr;
        if (ras.flush) begin
            tos_next   = '0;
            count_next = '0;
        end else if (ras.ckpt_restore) begin
            if (rd_slot.valid) begin
                tos_next   = rd_slot.tos;
                count_next = rd_slot.count;
                wr_en      = 1'b1;
                wr_idx     = rd_slot.tos;
                wr_data    = rd_slot.top;
            end else begin
                ckpt_err_next = 1'b1;
            end
        end else if (ras.push && (!ras.pop || count_reg == '0)) begin
            tos_next   = tos_inc;
            wr_en      = 1'b1;
            count_next = (count_reg == CNT_W'(DEPTH)) ? count_reg : count_reg + 1'b1;
        end else if (ras.push && ras.pop) begin
            // Return immediately followed by a call: replace the top in place.
            wr_en  = 1'b1;
            wr_idx = tos_reg;
        end else if (ras.pop && count_reg != '0) begin
            tos_next   = tos_dec;
            count_next = count_reg - 1'b1;
        end
    end

    // A save records the post-update top, so forward this cycle's write.
    assign top_next  = (wr_en && wr_idx == tos_next) ? wr_data : entry_reg[tos_next];
    assign save_en   = ras.ckpt_save && !ras.flush && !ras.ckpt_restore;
    assign save_slot = '{valid: 1'b1, tos: tos_next, count: count_next, top: top_next};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tos_reg      <= '0;
            count_reg    <= '0;
            ckpt_err_reg <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            tos_reg      <= tos_next;
            count_reg    <= count_next;
            ckpt_err_reg <= ckpt_err_next;
            if (wr_en) begin
                entry_reg[wr_idx] <= wr_data;
            end
        end
    end

    cva6_ras_ckpt_file #(
        .NR_CKPT (NR_CKPT),
        .SLOT_W  ($bits(ras_ckpt_t))
    ) u_ckpt_file (
        .clk     (clk_i),
        .srst    (rst_i),
        .flush   (ras.flush),
        .wr_en   (save_en),
        .wr_idx  (ras.ckpt_idx),
        .wr_data (save_slot),
        .rd_idx  (ras.ckpt_idx),
        .rd_data (rd_slot)
    );

    assign ras.top       = (count_reg != '0) ? entry_reg[tos_reg] : '0;
    assign ras.top_valid = (count_reg != '0);
    assign ras.count     = count_reg;
    assign ras.ckpt_err  = ckpt_err_reg;
endmodule
